xor_mix_sched: RTL and testbench

XOR_MIX_SCHED -- requirements
Module: xor_mix_sched

---
 rtl/xor_mix_pkg.sv | 24 ++
 rtl/xor_mix_core.sv | 18 +
 rtl/xor_mix_sched.sv | 208 ++++++++++++++++++++
 tb/tb_xor_mix_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_mix_pkg.sv
// Shared types and constants for the XOR mix scheduler.
package xor_mix_pkg;

    // Width of the accepted-operation counter.
    localparam int unsigned CNT_W = 16;

    // Requester id width stored in the buffer; covers the widest legal NUM_REQ (8).
    localparam int unsigned RES_ID_W = 3;

    // Occupancy state of the result buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    // One buffered result.
    typedef struct packed {
        logic [2:0]          c;
        logic                z;
        logic [RES_ID_W-1:0] id;
    } mix_res_t;

endpackage

// File: rtl/xor_mix_core.sv
// Combinational XOR mix datapath applied to the granted operands.
module xor_mix_core (
    input  logic [2:0] a,
    input  logic [1:0] b,
    output logic [2:0] c,
    output logic       z
);

    logic [1:0] d;

    // Mix: low operand bits XOR b, swapped into c[2:1]; c[0] is the parity of a.
    always_comb begin
        d = a[1:0] ^ b;
        c = {d[0], d[1], ^a};
        z = c[1] ^ c[0];
    end

endmodule

// File: rtl/xor_mix_sched.sv
// Round-robin scheduler feeding a shared XOR mix datapath into a small
// flop-based FIFO of results.
module xor_mix_sched
    import xor_mix_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    parameter  int unsigned DEPTH   = 2,
    localparam int unsigned IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3*NUM_REQ-1:0] req_a,
    input  logic [2*NUM_REQ-1:0] req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_c,
    output logic                 out_z,
    output logic [IDW-1:0]       out_id,
    output logic [CNT_W-1:0]     op_count
);

    localparam int unsigned PTR_W = 2;
    localparam int unsigned OCC_W = 3;

    logic [IDW-1:0]     rr_q, rr_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    occ_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    mix_res_t           mem_q [DEPTH];

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [2:0]         a_sel;
    logic [1:0]         b_sel;
    logic [2:0]         mix_c;
    logic               mix_z;
    mix_res_t           wr_res;
    mix_res_t           head_res;
    logic               buf_full;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin search: first valid at or above rr_q, else first valid below it.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDW'(i) >= rr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[i] && (IDW'(i) < rr_q)) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_found && (grant_idx == IDW'(i))) begin
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                a_sel = req_a[3*i +: 3];
                b_sel = req_b[2*i +: 2];
            end
        end
    end

    xor_mix_core u_core (
        .a (a_sel),
        .b (b_sel),
        .c (mix_c),
        .z (mix_z)
    );

    // Grant is visible only out of reset and while the buffer has room.
    always_comb begin
        req_ready = (rst_n && !buf_full) ? grant_oh : '0;
        push      = |(req_valid & req_ready);
        pop       = out_valid & out_ready;
        wr_res    = '{c: mix_c, z: mix_z, id: RES_ID_W'(grant_idx)};
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
        end
    end

    // Occupancy next state: push-only grows, pop-only shrinks, both hold.
    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    occ_d   = OCC_W'(1);
                    state_d = PART;
                end
            end
            PART: begin
                if (push && !pop) begin
                    occ_d   = occ_q + OCC_W'(1);
                    state_d = (occ_d == OCC_W'(DEPTH)) ? FULL : PART;
                end else if (pop && !push) begin
                    occ_d   = occ_q - OCC_W'(1);
                    state_d = (occ_d == '0) ? EMPTY : PART;
                end
            end
            FULL: begin
                if (pop && !push) begin
                    occ_d   = occ_q - OCC_W'(1);
                    state_d = PART;
                end
            end
            default: begin
                occ_d   = '0;
                state_d = EMPTY;
            end
        endcase
    end

    // Occupancy-derived flags.
    always_comb begin
        out_valid = (state_q != EMPTY);
        buf_full  = (state_q == FULL);
    end

    // Pointer, round-robin and counter next values.
    always_comb begin
        tail_d = push ? ptr_next(tail_q) : tail_q;
        head_d = pop  ? ptr_next(head_q) : head_q;
        rr_d   = rr_q;
        if (push) begin
            rr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
        cnt_d  = push ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Pointers, round-robin pointer and operation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            rr_q   <= rr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Result storage, written at the tail on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (push && (tail_q == PTR_W'(k))) begin
                    mem_q[k] <= wr_res;
                end
            end
        end
    end

    // Head read; outputs are zero whenever the buffer is empty.
    always_comb begin
        head_res = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (head_q == PTR_W'(k)) begin
                head_res = mem_q[k];
            end
        end
        out_c    = out_valid ? head_res.c : '0;
        out_z    = out_valid ? head_res.z : 1'b0;
        out_id   = out_valid ? IDW'(head_res.id) : '0;
        op_count = cnt_q;
    end

endmodule

// File: tb/tb_xor_mix_sched.sv
// Self-checking bench for xor_mix_sched: constant vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_xor_mix_sched;

    localparam int N  = 2;
    localparam int D  = 2;
    localparam int AW = 3 * N;
    localparam int BW = 2 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [AW-1:0] req_a = '0;
    logic [BW-1:0] req_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    out_c;
    logic          out_z;
    logic [0:0]    out_id;
    logic [15:0]   op_count;

    always #5 clk = ~clk;

    xor_mix_sched #(.NUM_REQ(N), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_id    (out_id),
        .op_count  (op_count)
    );

    typedef struct {
        logic [2:0] c;
        logic       z;
        int         id;
    } exp_res_t;

    typedef struct {
        int         req;
        logic [2:0] a;
        logic [1:0] b;
        logic [2:0] c;
        logic       z;
    } vec_t;

    exp_res_t    mq[$];
    int          m_rr = 0;
    logic [15:0] m_cnt = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_res_t model_mix(input logic [2:0] a, input logic [1:0] b, input int id);
        exp_res_t   r;
        int         par;
        logic [1:0] d;
        par  = (int'(a[0]) + int'(a[1]) + int'(a[2])) % 2;
        d    = a[1:0] ^ b;
        r.c  = {d[0], d[1], (par == 1)};
        r.z  = d[1] ^ (par == 1);
        r.id = id;
        return r;
    endfunction

    function automatic int model_grant(input logic [N-1:0] v);
        int idx;
        if (mq.size() >= D) return -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rr  = 0;
        m_cnt = '0;
    endtask

    // One clock of traffic, entered and left at 1 time unit after a rising edge.
    task automatic cycle(input logic [N-1:0] v, input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic ordy, output logic [N-1:0] rdy_seen);
        int       g;
        exp_res_t r;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        out_ready = ordy;
        @(negedge clk);
        g        = model_grant(v);
        rdy_seen = req_ready;
        check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("out_valid", 32'(out_valid), (mq.size() > 0) ? 32'd1 : 32'd0);
        if (mq.size() > 0) begin
            check("out_c", 32'(out_c), 32'(mq[0].c));
            check("out_z", 32'(out_z), 32'(mq[0].z));
            check("out_id", 32'(out_id), 32'(mq[0].id));
        end
        check("op_count", 32'(op_count), 32'(m_cnt));
        @(posedge clk);
        if (ordy && mq.size() > 0) void'(mq.pop_front());
        if (g >= 0) begin
            r = model_mix(a[3*g +: 3], b[2*g +: 2], g);
            mq.push_back(r);
            m_rr  = (g + 1) % N;
            m_cnt = m_cnt + 16'd1;
        end
        #1;
    endtask

    initial begin
        vec_t          tbl[8];
        int            seq[4];
        logic [N-1:0]  rs;
        logic [AW-1:0] av;
        logic [BW-1:0] bv;
        int            exp_cnt;
        int            guard;

        tbl[0] = '{0, 3'b101, 2'b11, 3'b010, 1'b1};
        tbl[1] = '{0, 3'b111, 2'b00, 3'b111, 1'b0};
        tbl[2] = '{1, 3'b000, 2'b00, 3'b000, 1'b0};
        tbl[3] = '{1, 3'b001, 2'b00, 3'b101, 1'b1};
        tbl[4] = '{0, 3'b010, 2'b01, 3'b111, 1'b0};
        tbl[5] = '{1, 3'b100, 2'b10, 3'b011, 1'b0};
        tbl[6] = '{0, 3'b011, 2'b11, 3'b000, 1'b0};
        tbl[7] = '{1, 3'b110, 2'b01, 3'b110, 1'b1};
        seq = '{0, 1, 0, 1};

        // Reset values, with requests offered while in reset.
        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(out_c), 32'd0);
        check("rst_z", 32'(out_z), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_cnt", 32'(op_count), 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Vector table: one op each, result one cycle later.
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            av = '0;
            bv = '0;
            av[3*tbl[i].req +: 3] = tbl[i].a;
            bv[2*tbl[i].req +: 2] = tbl[i].b;
            cycle(N'(1 << tbl[i].req), av, bv, 1'b1, rs);
            exp_cnt++;
            check("tbl_ready", 32'(rs), 32'(1 << tbl[i].req));
            check("tbl_valid", 32'(out_valid), 32'd1);
            check("tbl_c", 32'(out_c), 32'(tbl[i].c));
            check("tbl_z", 32'(out_z), 32'(tbl[i].z));
            check("tbl_id", 32'(out_id), 32'(tbl[i].req));
            check("tbl_cnt", 32'(op_count), 32'(exp_cnt));
            cycle('0, AW'($urandom), BW'($urandom), 1'b1, rs);
            check("tbl_drain", 32'(out_valid), 32'd0);
        end

        // Backpressure: two accepted, third stalls until a slot frees up.
        cycle(2'b01, AW'({3'b000, tbl[0].a}), BW'({2'b00, tbl[0].b}), 1'b0, rs);
        check("bp_acc0", 32'(rs), 32'd1);
        cycle(2'b01, AW'({3'b000, tbl[1].a}), BW'({2'b00, tbl[1].b}), 1'b0, rs);
        check("bp_acc1", 32'(rs), 32'd1);
        for (int k = 0; k < 2; k++) begin
            cycle(2'b01, AW'({3'b000, tbl[2].a}), BW'({2'b00, tbl[2].b}), 1'b0, rs);
            check("bp_stall", 32'(rs), 32'd0);
            check("bp_hold_c", 32'(out_c), 32'(tbl[0].c));
            check("bp_hold_z", 32'(out_z), 32'(tbl[0].z));
        end
        cycle(2'b01, AW'({3'b000, tbl[2].a}), BW'({2'b00, tbl[2].b}), 1'b1, rs);
        check("bp_full_ordy", 32'(rs), 32'd0);
        check("bp_head1", 32'(out_c), 32'(tbl[1].c));
        cycle(2'b01, AW'({3'b000, tbl[2].a}), BW'({2'b00, tbl[2].b}), 1'b1, rs);
        check("bp_acc2", 32'(rs), 32'd1);
        check("bp_head2", 32'(out_c), 32'(tbl[2].c));
        check("bp_cnt", 32'(op_count), 32'd11);
        cycle('0, '0, '0, 1'b1, rs);
        check("bp_drain", 32'(out_valid), 32'd0);

        // Reset mid-flight with a full buffer.
        cycle(2'b10, AW'($urandom), BW'($urandom), 1'b0, rs);
        cycle(2'b10, AW'($urandom), BW'($urandom), 1'b0, rs);
        check("mid_full", 32'(out_valid), 32'd1);
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_cnt", 32'(op_count), 32'd0);
        check("mid_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        check("mid_stale", 32'(out_valid), 32'd0);

        // Fairness from a freshly reset pointer.
        for (int k = 0; k < 4; k++) begin
            cycle(2'b11, AW'($urandom), BW'($urandom), 1'b1, rs);
            check("fair_grant", 32'(rs), 32'(1 << seq[k]));
            check("fair_id", 32'(out_id), 32'(seq[k]));
        end

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            cycle(N'($urandom), AW'($urandom), BW'($urandom), ($urandom_range(0, 3) != 0), rs);
        end

        // Counter wrap.
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            cycle(2'b11, AW'($urandom), BW'($urandom), 1'b1, rs);
            guard++;
        end
        check("wrap_budget", 32'(guard < 70000), 32'd1);
        check("wrap_pre", 32'(op_count), 32'h0000FFFF);
        cycle(2'b11, AW'($urandom), BW'($urandom), 1'b1, rs);
        check("wrap_xfer", 32'(rs != '0), 32'd1);
        check("wrap_zero", 32'(op_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
